// File: rtl/mul_acc_if.sv
// Product-in / frame-sum-out signal bundle for the frame accumulator.
interface mul_acc_if #(
  parameter int W     = 8,
  parameter int CNT_W = 2
);
  logic                 in_vld;
  logic [W-1:0]         in_data;
  logic                 in_last;
  logic                 out_vld;
  logic [W+CNT_W-1:0]   out_data;
  logic                 out_rdy;

  modport master (
    output in_vld, in_data, in_last, out_rdy,
    input  out_vld, out_data
  );

  modport slave (
    input  in_vld, in_data, in_last, out_rdy,
    output out_vld, out_data
  );
endinterface

// File: rtl/mul_acc.sv
// Frame accumulator for the non-stallable multiplier result stream; the frame sum
// sits in a valid/ready output register and undeliverable sums are dropped and flagged.
module mul_acc #(
  parameter int W     = 8,
  parameter int LEN   = 4,
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  mul_acc_if.slave   bus,
  output logic       ovf,
  output logic       busy
);
  localparam int ACC_W = W + CNT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  logic [ACC_W-1:0] acc_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             out_vld_p1;
  logic [ACC_W-1:0] out_data_p1;
  logic             ovf_p1;

  logic             closing;
  logic             out_free;
  logic [ACC_W-1:0] sum;

  // Zero-extended add; ACC_W is sized so a full frame can never wrap.
  function automatic logic [ACC_W-1:0] add_ext(input logic [ACC_W-1:0] a,
                                               input logic [W-1:0] b);
    return a + ACC_W'(b);
  endfunction

  always_comb begin
    closing  = bus.in_vld && !clr && ((cnt_p0 == LAST_CNT) || bus.in_last);
    out_free = !out_vld_p1 || bus.out_rdy;
    sum      = add_ext(acc_p0, bus.in_data);
  end

  // Stage p0: running sum and product count of the open frame
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (clr) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (closing) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (bus.in_vld) begin
      acc_p0 <= sum;
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

  // Stage p1: output register; a completion into a taken slot only raises ovf
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_vld_p1  <= 1'b0;
      out_data_p1 <= '0;
      ovf_p1      <= 1'b0;
    end else begin
      if (clr)
        ovf_p1 <= 1'b0;
      else if (closing && !out_free)
        ovf_p1 <= 1'b1;

      if (closing && out_free) begin
        out_vld_p1  <= 1'b1;
        out_data_p1 <= sum;
      end else if (out_vld_p1 && bus.out_rdy) begin
        out_vld_p1  <= 1'b0;
      end
    end
  end

  assign bus.out_vld  = out_vld_p1;
  assign bus.out_data = out_data_p1;
  assign ovf          = ovf_p1;
  assign busy         = (cnt_p0 != '0);
endmodule

// File: tb/tb_mul_acc.sv
// Directed bench for mul_acc: a LEN=4 instance for most cases and a LEN=2 instance
// for the toggling-ready stream; delivered sums are checked against a scoreboard.
module tb_mul_acc;
  logic clk;
  logic rstn;
  logic clr_a, clr_b;
  logic ovf_a, busy_a, ovf_b, busy_b;

  int vectors;
  int miscompares;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  mul_acc_if #(.W(8), .CNT_W(2)) bus_a ();
  mul_acc_if #(.W(8), .CNT_W(1)) bus_b ();

  mul_acc #(.W(8), .LEN(4), .CNT_W(2)) u_dut_a (
    .clk(clk), .rstn(rstn), .clr(clr_a), .bus(bus_a.slave), .ovf(ovf_a), .busy(busy_a)
  );

  mul_acc #(.W(8), .LEN(2), .CNT_W(1)) u_dut_b (
    .clk(clk), .rstn(rstn), .clr(clr_b), .bus(bus_b.slave), .ovf(ovf_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake must match the oldest pending expected sum.
  always @(negedge clk) begin
    if (rstn && bus_a.out_vld && bus_a.out_rdy) begin
      check("pending_a", 32'(q_a.size() != 0), 1);
      if (q_a.size() != 0) check("sum_a", 32'(bus_a.out_data), q_a.pop_front());
    end
    if (rstn && bus_b.out_vld && bus_b.out_rdy) begin
      check("pending_b", 32'(q_b.size() != 0), 1);
      if (q_b.size() != 0) check("sum_b", 32'(bus_b.out_data), q_b.pop_front());
    end
  end

  // Apply one cycle of stimulus to instance A, then step past the next rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic r, input logic c);
    bus_a.in_vld  = v;
    bus_a.in_data = d;
    bus_a.in_last = l;
    bus_a.out_rdy = r;
    clr_a         = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, r, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p0, p1;
    vectors     = 0;
    miscompares = 0;
    rstn = 1'b0;
    clr_b = 1'b0;
    bus_b.in_vld = 1'b0; bus_b.in_data = '0; bus_b.in_last = 1'b0; bus_b.out_rdy = 1'b0;

    // 1: reset with in_vld held high
    step(1'b1, 8'd5, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'd5, 1'b0, 1'b1, 1'b0);
    check("rst_out_vld", 32'(bus_a.out_vld), 0);
    check("rst_out_data", 32'(bus_a.out_data), 0);
    check("rst_ovf", 32'(ovf_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_out_vld_b", 32'(bus_b.out_vld), 0);
    rstn = 1'b1;
    idle(1, 1'b1);

    // 2: full frame of maxima
    for (int i = 0; i < 4; i++) step(1'b1, 8'd255, 1'b0, 1'b1, 1'b0);
    q_a.push_back(1020);
    check("max_vld", 32'(bus_a.out_vld), 1);
    check("max_data", 32'(bus_a.out_data), 1020);
    idle(1, 1'b1);
    check("max_one_cycle", 32'(bus_a.out_vld), 0);

    // 3: early in_last
    step(1'b1, 8'd3, 1'b0, 1'b1, 1'b0);
    check("busy_mid", 32'(busy_a), 1);
    step(1'b1, 8'd5, 1'b1, 1'b1, 1'b0);
    q_a.push_back(8);
    check("early_busy", 32'(busy_a), 0);

    // 4: normal frame then one-product frame, back to back
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
    q_a.push_back(4);
    step(1'b1, 8'd7, 1'b1, 1'b1, 1'b0);
    q_a.push_back(7);
    check("one_prod_data", 32'(bus_a.out_data), 7);
    idle(2, 1'b1);

    // 5: stalled consumer, second frame dropped
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    q_a.push_back(10);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    check("stall_data", 32'(bus_a.out_data), 10);
    check("stall_vld", 32'(bus_a.out_vld), 1);
    check("stall_ovf", 32'(ovf_a), 1);
    idle(1, 1'b1);
    check("stall_drain", 32'(bus_a.out_vld), 0);
    check("ovf_sticky", 32'(ovf_a), 1);

    // 6: clr aborts a partial frame and drops its own sample
    step(1'b1, 8'd9, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'd9, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'd9, 1'b0, 1'b1, 1'b1);
    check("clr_busy", 32'(busy_a), 0);
    check("clr_ovf", 32'(ovf_a), 0);
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
    q_a.push_back(10);
    check("clr_data", 32'(bus_a.out_data), 10);
    idle(2, 1'b1);

    // 8: reset mid-frame discards the partial sum
    step(1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
    rstn = 1'b0;
    idle(1, 1'b1);
    check("midrst_busy", 32'(busy_a), 0);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
    q_a.push_back(4);
    check("midrst_data", 32'(bus_a.out_data), 4);
    idle(2, 1'b1);

    // 7: LEN=2 stream with out_rdy toggling every cycle
    for (int f = 0; f < 12; f++) begin
      p0 = 8'($urandom_range(0, 255));
      p1 = 8'($urandom_range(0, 255));
      bus_b.in_vld = 1'b1; bus_b.in_data = p0; bus_b.in_last = 1'b0;
      bus_b.out_rdy = ~bus_b.out_rdy;
      @(posedge clk); #1;
      bus_b.in_data = p1;
      bus_b.out_rdy = ~bus_b.out_rdy;
      q_b.push_back(32'(p0) + 32'(p1));
      @(posedge clk); #1;
    end
    bus_b.in_vld = 1'b0;
    bus_b.out_rdy = 1'b1;
    idle(4, 1'b1);
    check("toggle_ovf", 32'(ovf_b), 0);
    check("toggle_vld", 32'(bus_b.out_vld), 0);

    check("drain_a", 32'(q_a.size()), 0);
    check("drain_b", 32'(q_b.size()), 0);
    check("final_ovf_a", 32'(ovf_a), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
